// File: rtl/seg_pkg.sv
// Shared constants, state type and digit-select helper for the seven-segment scan controller.
package seg_pkg;

    localparam int unsigned DIG_W   = 4;
    localparam int unsigned BCD_W   = 20;
    localparam int unsigned WIN_W   = 2;
    localparam int unsigned SCAN_W  = 2;
    localparam int unsigned WIN_MAX = 2;

    localparam logic [DIG_W-1:0] GLYPH_BLANK = 4'hF;
    localparam logic [DIG_W-1:0] GLYPH_MINUS = 4'hA;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_e;

    // Select BCD digit idx (0 = least significant) from the packed product.
    function automatic logic [DIG_W-1:0] bcd_pick(input logic [BCD_W-1:0] bcd, input logic [2:0] idx);
        logic [DIG_W-1:0] d;
        case (idx)
            3'd0:    d = bcd[3:0];
            3'd1:    d = bcd[7:4];
            3'd2:    d = bcd[11:8];
            3'd3:    d = bcd[15:12];
            3'd4:    d = bcd[19:16];
            default: d = GLYPH_BLANK;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability counter and rising-edge press pulse for one raw button.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    // A differing sample run of DEBOUNCE_CYCLES flips the level; any matching sample restarts the run.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                press_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scheduler: blanks until a product is final, then scans a scrollable
// three-digit window of the BCD product plus a sign slot.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV     = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              result_valid,
    input  logic              clear,
    input  logic [BCD_W-1:0]  bcd_in,
    input  logic              sign,
    output logic [3:0]        anode,
    output logic [DIG_W-1:0]  digit,
    output logic [WIN_W-1:0]  window
);

    localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [WIN_W-1:0] WIN_TOP  = WIN_W'(WIN_MAX);

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [SCAN_W-1:0]   scan_q, scan_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [3:0]          anode_q, anode_d;
    logic [DIG_W-1:0]    digit_q, digit_d;
    logic [2:0]          slot_idx;
    logic                left_press, right_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .clk     (clk),
        .rst_n   (rst),
        .btn_i   (btn_left),
        .press_o (left_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .clk     (clk),
        .rst_n   (rst),
        .btn_i   (btn_right),
        .press_o (right_press)
    );

    // Outputs are computed from the current state, but clear blanks them one cycle early.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        scan_d   = scan_q;
        win_d    = win_q;
        anode_d  = 4'hF;
        digit_d  = GLYPH_BLANK;
        slot_idx = 3'(win_q) + 3'(scan_q);

        case (state_q)
            IDLE: begin
                div_d  = '0;
                scan_d = '0;
                win_d  = '0;
                if (result_valid && !clear) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (clear) begin
                    state_d = IDLE;
                    div_d   = '0;
                    scan_d  = '0;
                    win_d   = '0;
                end else begin
                    if (div_q == DIV_LAST) begin
                        div_d  = '0;
                        scan_d = scan_q + SCAN_W'(1);
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end

                    if (left_press && !right_press && (win_q != WIN_TOP)) begin
                        win_d = win_q + WIN_W'(1);
                    end else if (right_press && !left_press && (win_q != '0)) begin
                        win_d = win_q - WIN_W'(1);
                    end

                    anode_d = ~(4'b0001 << scan_q);
                    if (scan_q == SCAN_W'(3)) begin
                        digit_d = sign ? GLYPH_MINUS : GLYPH_BLANK;
                    end else begin
                        digit_d = bcd_pick(bcd_in, slot_idx);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            scan_q  <= '0;
            win_q   <= '0;
            anode_q <= 4'hF;
            digit_q <= GLYPH_BLANK;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            scan_q  <= scan_d;
            win_q   <= win_d;
            anode_q <= anode_d;
            digit_q <= digit_d;
        end
    end

    assign anode  = anode_q;
    assign digit  = digit_q;
    assign window = win_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: blanking, scan order, scrolling, debounce and clear/reset behaviour.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_left;
    logic        btn_right;
    logic        result_valid;
    logic        clear;
    logic [19:0] bcd_in;
    logic        sign;
    logic [3:0]  anode;
    logic [3:0]  digit;
    logic [1:0]  window;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .REFRESH_DIV     (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .result_valid (result_valid),
        .clear        (clear),
        .bcd_in       (bcd_in),
        .sign         (sign),
        .anode        (anode),
        .digit        (digit),
        .window       (window)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for a given anode pattern; a timeout is reported as a failed comparison.
    task automatic wait_anode(input logic [3:0] val, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (anode == val) found = 1'b1;
        end
        if (!found) check({tag, "_timeout"}, 32'(anode), 32'(val));
    endtask

    // Align to the start of a frame, then check each slot's anode (first and last cycle) and digit.
    task automatic check_frame(input string tag, input logic [3:0] d0, input logic [3:0] d1,
                               input logic [3:0] d2, input logic [3:0] d3);
        logic [3:0] an_exp [4];
        logic [3:0] dg_exp [4];
        an_exp = '{4'hE, 4'hD, 4'hB, 4'h7};
        dg_exp = '{d0, d1, d2, d3};
        wait_anode(4'h7, tag);
        wait_anode(4'hE, tag);
        for (int s = 0; s < 4; s++) begin
            check($sformatf("%s_an%0d", tag, s), 32'(anode), 32'(an_exp[s]));
            check($sformatf("%s_dg%0d", tag, s), 32'(digit), 32'(dg_exp[s]));
            cyc(3);
            check($sformatf("%s_hold%0d", tag, s), 32'(anode), 32'(an_exp[s]));
            cyc(1);
        end
    endtask

    task automatic press(input logic l, input logic r, input int hold);
        btn_left  = l;
        btn_right = r;
        cyc(hold);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        cyc(20);
    endtask

    initial begin
        rst          = 1'b0;
        btn_left     = 1'b0;
        btn_right    = 1'b0;
        result_valid = 1'b1;
        clear        = 1'b0;
        bcd_in       = 20'h00270;
        sign         = 1'b0;

        // Held in reset with result_valid high: blank
        cyc(3);
        check("rst_anode", 32'(anode), 32'h F);
        check("rst_digit", 32'(digit), 32'h F);
        check("rst_window", 32'(window), 32'h0);

        // Release: SHOW after one edge, first lit digit after two
        rst = 1'b1;
        cyc(1);
        check("entry_blank", 32'(anode), 32'hF);
        cyc(1);
        check("entry_anode", 32'(anode), 32'hE);
        check("entry_digit", 32'(digit), 32'h0);

        check_frame("w0", 4'h0, 4'h7, 4'h2, 4'hF);

        // Scroll up with saturation
        press(1'b1, 1'b0, 20);
        check("left1_win", 32'(window), 32'd1);
        check_frame("w1", 4'h7, 4'h2, 4'h0, 4'hF);
        press(1'b1, 1'b0, 20);
        check("left2_win", 32'(window), 32'd2);
        check_frame("w2", 4'h2, 4'h0, 4'h0, 4'hF);
        press(1'b1, 1'b0, 20);
        check("left3_sat", 32'(window), 32'd2);

        // Scroll down with saturation
        press(1'b0, 1'b1, 20);
        check("right1_win", 32'(window), 32'd1);
        press(1'b0, 1'b1, 20);
        check("right2_win", 32'(window), 32'd0);
        press(1'b0, 1'b1, 20);
        check("right3_sat", 32'(window), 32'd0);

        // Negative product shows minus glyph in the sign slot
        sign = 1'b1;
        check_frame("neg", 4'h0, 4'h7, 4'h2, 4'hA);
        sign = 1'b0;

        // Short glitch is rejected
        press(1'b1, 1'b0, 5);
        check("glitch_win", 32'(window), 32'd0);

        // Simultaneous presses cancel
        press(1'b1, 1'b0, 20);
        check("pre_both_win", 32'(window), 32'd1);
        press(1'b1, 1'b1, 20);
        check("both_win", 32'(window), 32'd1);

        // Clear during slot 1 blanks next cycle and resets the window
        press(1'b1, 1'b0, 20);
        check("pre_clear_win", 32'(window), 32'd2);
        wait_anode(4'hD, "clr_sync");
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        check("clear_anode", 32'(anode), 32'hF);
        check("clear_digit", 32'(digit), 32'hF);
        check("clear_window", 32'(window), 32'd0);

        // clear and result_valid together keep the display idle
        clear = 1'b1;
        cyc(3);
        check("clr_rv_anode_a", 32'(anode), 32'hF);
        cyc(3);
        check("clr_rv_anode_b", 32'(anode), 32'hF);
        check("clr_rv_window", 32'(window), 32'd0);
        clear = 1'b0;
        cyc(1);
        check("reentry_blank", 32'(anode), 32'hF);
        cyc(1);
        check("reentry_anode", 32'(anode), 32'hE);

        // Asynchronous reset between edges
        press(1'b1, 1'b0, 20);
        check("pre_arst_win", 32'(window), 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_anode", 32'(anode), 32'hF);
        check("arst_digit", 32'(digit), 32'hF);
        check("arst_window", 32'(window), 32'd0);
        cyc(2);
        rst = 1'b1;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
